otter_intr_ctrl: RTL

//  Interrupt source side of the OTTER interrupt handshake. Collects external IRQ lines,

---
 rtl/otter_intr_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: interrupt source side of the OTTER interrupt handshake.
// External IRQ lines are synchronized, rising-edge detected and latched in
// PENDING. The highest-priority enabled pending source (lowest index) raises
// INTR. The CPU answers with INT_TAKEN, and the trap handler ends service by
// writing EOI. PENDING, MASK and STATUS are visible on a small MMIO window.
module otter_intr_ctrl #(
  parameter int unsigned NUM_SRC     = 8,  // 1..16, index 0 = highest priority
  parameter int unsigned SYNC_STAGES = 2   // synchronizer depth, >= 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] irq_in_i,
  input  logic               csr_mie_i,
  input  logic               int_taken_i,
  output logic               intr_o,
  output logic [3:0]         int_id_o,
  output logic               in_svc_o,
  input  logic [3:0]         addr_i,
  input  logic [31:0]        wd_i,
  input  logic               wr_en_i,
  output logic [31:0]        rd_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REG_PENDING = 2'd0,
    REG_MASK    = 2'd1,
    REG_STATUS  = 2'd2,
    REG_EOI     = 2'd3
  } reg_sel_e;

  // Synchronizer chain, edge register and the priming shift register.
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] edge_q;
  logic [SYNC_STAGES:0] fill_q;

  logic [NUM_SRC-1:0] sync_out;
  logic               primed;
  logic [NUM_SRC-1:0] rise;

  // Architectural state.
  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [3:0]         int_id_q, int_id_d;

  // Decode and priority.
  reg_sel_e           reg_sel;
  logic               wr_pending, wr_mask, wr_eoi;
  logic [NUM_SRC-1:0] pend_en;
  logic [NUM_SRC-1:0] sel_oh;
  logic [3:0]         sel_id;
  logic               req;
  logic               take;

  // Only ADDR[3:2] selects a register; low address bits and unused write data
  // bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], wd_i};

  assign sync_out = sync_q[SYNC_STAGES-1];

  // The edge detector only arms once the chain holds real samples and the
  // edge register has seen one of them. A line already high when reset is
  // released therefore reads as a held level, not a fresh edge, and must
  // drop and rise again before it pends.
  assign primed = fill_q[SYNC_STAGES];
  assign rise   = sync_out & ~edge_q & {NUM_SRC{primed}};

  // Synchronize IRQ lines, track the previous synced level, count priming.
  // NOTE: every flop here, the synchronizer included, takes the async reset so
  // a reset mid-handshake cannot leave stale samples to be seen as edges.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
      edge_q <= '0;
      fill_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the value the
      // previous stage held before this edge, which is what forms the chain.
      sync_q[0] <= irq_in_i;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      edge_q <= sync_out;
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign reg_sel    = reg_sel_e'(addr_i[3:2]);
  assign wr_pending = wr_en_i && (reg_sel == REG_PENDING);
  assign wr_mask    = wr_en_i && (reg_sel == REG_MASK);
  assign wr_eoi     = wr_en_i && (reg_sel == REG_EOI);

  // Lowest set bit of the enabled pending vector wins.
  assign pend_en = pend_q & mask_q;
  assign sel_oh  = pend_en & (~pend_en + 1'b1);
  assign req     = |pend_en;

  // Encode the one-hot winner into a source ID.
  always_comb begin
    sel_id = 4'd0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (pend_en[i]) begin
        sel_id = 4'(i);
      end
    end
  end

  // A take is only honoured while requesting with a real winner to service.
  assign take = (state_q == REQ) && int_taken_i && req;

  // Next-state logic for the handshake FSM and the service ID.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    state_d  = state_q;
    int_id_d = int_id_q;
    unique case (state_q)
      IDLE: begin
        if (req && csr_mie_i) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (take) begin
          state_d  = SVC;
          int_id_d = sel_id;
        end else if (!req || !csr_mie_i) begin
          // Request withdrawn before the CPU took it; pending bits remain.
          state_d = IDLE;
        end
      end
      SVC: begin
        // INT_TAKEN is ignored here, so an EOI in the same cycle still wins.
        if (wr_eoi) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next-state logic for PENDING and MASK. Applying new edges last lets a
  // fresh edge override both a W1C and the take-clear of the same bit.
  always_comb begin
    pend_d = pend_q;
    mask_d = mask_q;
    if (wr_pending) begin
      pend_d = pend_d & ~wd_i[NUM_SRC-1:0];
    end
    if (take) begin
      pend_d = pend_d & ~sel_oh;
    end
    pend_d = pend_d | rise;
    if (wr_mask) begin
      mask_d = wd_i[NUM_SRC-1:0];
    end
  end

  // Architectural registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      mask_q   <= '0;
      int_id_q <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      int_id_q <= int_id_d;
    end
  end

  assign intr_o   = (state_q == REQ);
  assign in_svc_o = (state_q == SVC);
  assign int_id_o = int_id_q;

  // MMIO read mux, combinational from ADDR.
  always_comb begin
    rd_o = 32'h0;
    unique case (reg_sel)
      REG_PENDING: rd_o = 32'(pend_q);
      REG_MASK:    rd_o = 32'(mask_q);
      REG_STATUS:  rd_o = {in_svc_o, intr_o, 26'h0, int_id_q};
      REG_EOI:     rd_o = 32'h0;
      default:     rd_o = 32'h0;
    endcase
  end

endmodule
